imem_fetch_ctrl: RTL
====================

Name: imem_fetch_ctrl

Overview:
Sequencer for the 32-bit-wide, 16-bit-addressed instruction memory. After reset it boot-loads a program image into the memory through a valid/ready stream. It then runs the program counter, issuing one registered instruction per cycle to the decode stage. It also applies stall, branch and jump redirects and halts on out-of-range targets.

Parameters:
ADDR_W, 16, instruction memory address width
DATA_W, 32, instruction word width
MEM_DEPTH, 12, number of implemented instruction words (valid addresses 0..MEM_DEPTH-1)

Ports:
clk  in  1  single system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
load_valid  in  1  boot-image word available
load_data  in  DATA_W  boot-image word
load_last  in  1  marks final boot-image word
load_ready  out  1  controller accepts load word this cycle
imem_we  out  1  instruction memory write enable
imem_waddr  out  ADDR_W  instruction memory write address
imem_wdata  out  DATA_W  instruction memory write data
imem_addr  out  ADDR_W  instruction memory read address (equals pc)
imem_rdata  in  DATA_W  instruction memory read data, combinational from imem_addr
stall  in  1  decode cannot accept; hold pc and inst_out
branch_taken  in  1  redirect request from branch unit
branch_target  in  ADDR_W  branch destination
jump  in  1  unconditional redirect request
jump_target  in  ADDR_W  jump destination
halt_req  in  1  stop fetching
inst_out  out  DATA_W  registered instruction to decode
inst_valid  out  1  inst_out holds a live instruction
pc_out  out  ADDR_W  address of instruction in inst_out
running  out  1  state == RUN
fault  out  1  sticky, out-of-range redirect detected

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=LOAD, pc=0, load count=0. inst_out=0, inst_valid=0, pc_out=0, fault=0, imem_we=0, running=0. Reset mid-load or mid-run restarts the boot load; memory contents are not cleared.
- States: LOAD, RUN, HALT.
- LOAD:
  - load_ready=1 while count<MEM_DEPTH.
  - On load_valid&&load_ready: imem_we=1, imem_waddr=count, imem_wdata=load_data (combinational, same cycle), count++.
  - Go to RUN after accepting a word with load_last=1, or after accepting word MEM_DEPTH-1, whichever comes first. Excess words are never accepted.
  - pc=0 on entry to RUN; inst_valid stays 0 in LOAD.
- RUN:
  - imem_addr=pc.
  - Each cycle with stall=0 and no redirect: inst_out<=imem_rdata, pc_out<=pc, inst_valid<=1, pc<=pc+1. pc wraps from MEM_DEPTH-1 to 0.
  - stall=1: pc, inst_out, pc_out and inst_valid hold.
  - Redirect priority: jump > branch_taken. Redirects are honoured even when stall=1.
  - On redirect: pc<=target, inst_valid<=0 for one cycle (bubble; the fetched word is discarded). The target instruction appears at inst_out on the following non-stalled cycle, so redirect-to-valid latency is 2 cycles.
  - If target>=MEM_DEPTH: fault<=1, inst_valid<=0, state->HALT, pc unchanged.
  - halt_req (lower priority than redirect in the same cycle only for fault detection; otherwise taken): state->HALT, inst_valid<=0.
- HALT: pc and outputs frozen, inst_valid=0, load_ready=0. The only exit is reset.
- running=1 only in RUN. load_ready=0 outside LOAD. imem_we=0 outside LOAD.
- No arithmetic beyond pc+1 (ADDR_W-bit) and the compare against MEM_DEPTH.

Decomposition:
- Shared package/header: state encodings (LOAD=2'd0, RUN=2'd1, HALT=2'd2), ADDR_W/DATA_W defaults, MEM_DEPTH constant shared with the instruction memory.
- One natural sub-module: imem_boot_loader, which holds the LOAD-state counter and the valid/ready-to-write-port conversion and signals load_done. The fetch FSM and pc stay in the top module.

Test Plan:
- Reset, stream 3 words 0xA,0xB,0xC with last on 0xC -> imem writes to addr 0,1,2; RUN next cycle; inst_out 0xA,0xB,0xC at pc_out 0,1,2 on consecutive cycles.
- Stream 14 words, no last -> exactly 12 accepted (load_ready low after the 12th), RUN entered; pc runs 0..11 then wraps to 0.
- In RUN at pc=4, jump=1 target=0 with branch_taken=1 target=7 -> one bubble cycle (inst_valid=0), then pc_out=0.
- stall held 3 cycles at pc_out=2 -> inst_out/pc_out unchanged, then resumes with pc_out=3.
- branch_taken target=20 -> fault=1, HALT, inst_valid=0 permanently until reset; reset clears fault and returns to LOAD.
- Assert reset during LOAD after 2 words -> load count restarts at 0, next accepted word written to addr 0.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer and the instruction
// memory it feeds: default geometry and the fetch state encoding.
package imem_fetch_ctrl_pkg;

  localparam int unsigned IMEM_ADDR_W    = 16;
  localparam int unsigned IMEM_DATA_W    = 32;
  localparam int unsigned IMEM_MEM_DEPTH = 12;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot-image loader: converts the load valid/ready stream into instruction
// memory write-port cycles and reports when the final word has been accepted.
//   clk, reset        : system clock, synchronous active-high reset
//   active            : controller is in the LOAD state
//   load_valid/data/last, load_ready : boot-image stream
//   imem_we/waddr/wdata               : instruction memory write port
//   load_done         : pulses in the cycle the final word is accepted
module imem_boot_loader
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned DATA_W    = IMEM_DATA_W,
  parameter int unsigned MEM_DEPTH = IMEM_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] count;
  logic              accept;

  always_comb begin
    load_ready = active && (count < DEPTH);
    accept     = load_valid && load_ready;
    imem_we    = accept;
    imem_waddr = count;
    imem_wdata = load_data;
    // Image ends on an explicit last marker or when memory is full.
    load_done  = accept && (load_last || (count == LAST));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (accept) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer. Boot-loads the instruction memory, then runs
// the program counter, presenting one registered instruction per cycle to
// decode, with stall, jump/branch redirects and halt/fault handling.
//   clk, reset                 : system clock, synchronous active-high reset
//   load_valid/data/last/ready : boot-image stream
//   imem_we/waddr/wdata        : instruction memory write port
//   imem_addr, imem_rdata      : instruction memory read port (async read)
//   stall                      : decode back-pressure
//   branch_taken/target, jump/jump_target : redirect requests
//   halt_req                   : stop fetching
//   inst_out/inst_valid/pc_out : registered instruction to decode
//   running, fault             : status (fault is sticky until reset)
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned DATA_W    = IMEM_DATA_W,
  parameter int unsigned MEM_DEPTH = IMEM_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt_req,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              running,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

  fetch_state_e      state, next_state;
  logic [ADDR_W-1:0] pc;
  logic              loader_active;
  logic              load_done;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              target_oob;

  imem_boot_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_boot_loader (
    .clk        (clk),
    .reset      (reset),
    .active     (loader_active),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .load_done  (load_done)
  );

  // Redirect decode: jump outranks branch.
  always_comb begin
    redirect        = jump || branch_taken;
    redirect_target = jump ? jump_target : branch_target;
    target_oob      = redirect && (redirect_target >= DEPTH);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD: if (load_done) next_state = ST_RUN;
      ST_RUN:  if (target_oob || halt_req) next_state = ST_HALT;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_LOAD;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    loader_active = (state == ST_LOAD);
    running       = (state == ST_RUN);
    imem_addr     = pc;
  end

  // Fetch datapath. A bad redirect target faults before halt_req is
  // considered; a valid redirect or halt bubbles inst_valid even under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      inst_out   <= '0;
      pc_out     <= '0;
      inst_valid <= 1'b0;
      fault      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          inst_valid <= 1'b0;
          if (load_done) pc <= '0;
        end
        ST_RUN: begin
          if (target_oob) begin
            fault      <= 1'b1;
            inst_valid <= 1'b0;
          end else if (halt_req) begin
            inst_valid <= 1'b0;
          end else if (redirect) begin
            pc         <= redirect_target;
            inst_valid <= 1'b0;
          end else if (!stall) begin
            inst_out   <= imem_rdata;
            pc_out     <= pc;
            inst_valid <= 1'b1;
            pc         <= (pc == LAST) ? '0 : pc + ADDR_W'(1);
          end
        end
        default: inst_valid <= 1'b0;
      endcase
    end
  end

endmodule
